// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported memory between the instruction-fetch requester
//   and the data (load/store) requester. One owner at a time drives a
//   valid/ready transaction; completion returns registered read data and a
//   one-cycle done pulse to the owner.
//
//   Optional macro: FAIR_ARB_EN
//     defined   - ties in IDLE go to the requester not granted last
//                 (last_grant register, reset value = fetch)
//     undefined - fixed priority, data over fetch
//
//   Ports
//     clk, reset                 rising-edge clock, async active-high reset
//     if_req/if_addr             fetch request (held until if_done)
//     if_rdata/if_done           fetched word (registered), completion pulse
//     dm_req/dm_we/dm_addr/
//     dm_wdata                   data request (held until dm_done)
//     dm_rdata/dm_done           load data (registered), completion pulse
//     mem_valid/mem_we/
//     mem_addr/mem_wdata         registered memory transaction
//     mem_rdata/mem_ready        memory response
//     busy                       registered (state != IDLE)

module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          mem_valid,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_D = 2'd1,
    GRANT_I = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          mem_valid_q, mem_valid_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          if_done_q, if_done_d;
  logic          dm_done_q, dm_done_d;
  logic          busy_q, busy_d;

  // A requester whose done is high this cycle is masked, so a held req is
  // taken as a new request only one cycle later.
  logic dm_elig, if_elig, grant_dm, grant_if;

  assign dm_elig = dm_req & ~dm_done_q;
  assign if_elig = if_req & ~if_done_q;

`ifdef FAIR_ARB_EN
  // 1 = data granted last, 0 = fetch granted last
  logic last_grant_q, last_grant_d;

  assign grant_dm = dm_elig & (~if_elig | ~last_grant_q);
  assign grant_if = if_elig & ~grant_dm;
`else
  assign grant_dm = dm_elig;
  assign grant_if = if_elig & ~dm_elig;
`endif

  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_done_d   = 1'b0;
    dm_done_d   = 1'b0;
`ifdef FAIR_ARB_EN
    last_grant_d = last_grant_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d     = GRANT_D;
          mem_valid_d = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
`ifdef FAIR_ARB_EN
          last_grant_d = 1'b1;
`endif
        end else if (grant_if) begin
          state_d     = GRANT_I;
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
`ifdef FAIR_ARB_EN
          last_grant_d = 1'b0;
`endif
        end
      end
      GRANT_D: begin
        if (mem_ready) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          dm_done_d   = 1'b1;
          if (!mem_we_q) dm_rdata_d = mem_rdata;
        end
      end
      GRANT_I: begin
        if (mem_ready) begin
          state_d     = IDLE;
          mem_valid_d = 1'b0;
          if_done_d   = 1'b1;
          if_rdata_d  = mem_rdata;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      dm_done_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef FAIR_ARB_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_done_q   <= if_done_d;
      dm_done_q   <= dm_done_d;
      busy_q      <= busy_d;
`ifdef FAIR_ARB_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_done   = if_done_q;
  assign dm_done   = dm_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter. Requesters and the memory are
// driven randomly; a transaction-level reference (owner, planned wait count,
// completion data) predicts every output each cycle.
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          dm_req, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata, dm_rdata;
  logic          dm_done;
  logic          mem_valid, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_ready;
  logic          busy;

  mem_port_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: owner 0 = none, 1 = data, 2 = fetch
  int            owner;
  int            waits, cnt;
  logic          e_valid, e_we, e_if_done, e_dm_done;
  logic [31:0]   e_addr, e_wdata, e_if_rdata, e_dm_rdata;
`ifdef FAIR_ARB_EN
  int            last;
`endif

  task automatic model_reset();
    owner = 0; waits = 0; cnt = 0;
    e_valid = 0; e_we = 0; e_if_done = 0; e_dm_done = 0;
    e_addr = '0; e_wdata = '0; e_if_rdata = '0; e_dm_rdata = '0;
`ifdef FAIR_ARB_EN
    last = 2;
`endif
  endtask

  // One clock edge of the reference, using the inputs stable at that edge.
  task automatic model_step();
    logic d0, i0, ed, ei;
    int   pick;
    d0 = e_dm_done; i0 = e_if_done;
    e_dm_done = 0; e_if_done = 0;
    if (owner != 0) begin
      if (mem_ready) begin
        if (owner == 1) begin
          e_dm_done = 1;
          if (!e_we) e_dm_rdata = mem_rdata;
        end else begin
          e_if_done  = 1;
          e_if_rdata = mem_rdata;
        end
        owner   = 0;
        e_valid = 0;
      end
    end else begin
      ed = dm_req && !d0;
      ei = if_req && !i0;
      pick = 0;
`ifdef FAIR_ARB_EN
      if (ed && ei) pick = (last == 2) ? 1 : 2;
      else if (ed)  pick = 1;
      else if (ei)  pick = 2;
      if (pick != 0) last = pick;
`else
      if (ed)      pick = 1;
      else if (ei) pick = 2;
`endif
      if (pick == 1) begin
        e_we = dm_we; e_addr = dm_addr; e_wdata = dm_wdata;
      end else if (pick == 2) begin
        e_we = 0; e_addr = if_addr;
      end
      if (pick != 0) begin
        owner = pick; e_valid = 1;
        waits = $urandom_range(0, 2); cnt = 0;
      end
    end
  endtask

  task automatic check_all();
    check("mem_valid", {31'd0, mem_valid}, {31'd0, e_valid});
    check("busy",      {31'd0, busy},      {31'd0, (owner != 0)});
    check("if_done",   {31'd0, if_done},   {31'd0, e_if_done});
    check("dm_done",   {31'd0, dm_done},   {31'd0, e_dm_done});
    check("if_rdata",  if_rdata, e_if_rdata);
    check("dm_rdata",  dm_rdata, e_dm_rdata);
    if (e_valid) begin
      check("mem_we",    {31'd0, mem_we}, {31'd0, e_we});
      check("mem_addr",  mem_addr,  e_addr);
      if (e_we) check("mem_wdata", mem_wdata, e_wdata);
    end
  endtask

  task automatic new_dm();
    dm_req = 1; dm_we = 1'($urandom); dm_addr = $urandom; dm_wdata = $urandom;
  endtask

  task automatic new_if();
    if_req = 1; if_addr = $urandom;
  endtask

  initial begin
    reset = 1;
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0; mem_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_mem_we",    {31'd0, mem_we},    32'd0);
    check("rst_mem_addr",  mem_addr,  32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check_all();
    reset = 0;

    for (int unsigned cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk);
      model_step();
      #1;
      check_all();

      if (owner != 0) begin
        mem_ready = (cnt == waits);
        cnt++;
      end else begin
        mem_ready = 0;
      end
      mem_rdata = $urandom;

      if (e_dm_done) begin
        if ($urandom_range(0, 1) == 1) new_dm(); else dm_req = 0;
      end else if (!dm_req) begin
        if (owner != 1 && $urandom_range(0, 2) == 0) new_dm();
      end else if (owner == 1 && $urandom_range(0, 15) == 0) begin
        dm_req = 0;
      end

      if (e_if_done) begin
        if ($urandom_range(0, 1) == 1) new_if(); else if_req = 0;
      end else if (!if_req) begin
        if (owner != 2 && $urandom_range(0, 2) == 0) new_if();
      end else if (owner == 2 && $urandom_range(0, 15) == 0) begin
        if_req = 0;
      end

      // Asynchronous reset in the middle of a transaction.
      if (owner != 0 && cyc > 20 && $urandom_range(0, 39) == 0) begin
        #3 reset = 1;
        #1;
        check("arst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("arst_busy",      {31'd0, busy},      32'd0);
        check("arst_dm_done",   {31'd0, dm_done},   32'd0);
        check("arst_if_done",   {31'd0, if_done},   32'd0);
        model_reset();
        mem_ready = 0;
        @(posedge clk);
        #1 reset = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
